// File: rtl/capture_sequencer_pkg.sv
// Shared types for the capture sequencer: the acquisition state encoding and
// small state-classification helpers used by the write path and status decode.
package capture_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PRE  = 3'd2,
        ARM  = 3'd3,
        WAIT = 3'd4,
        POST = 3'd5,
        DONE = 3'd6
    } capture_state_t;

    // States in which a valid sample is written into the sample RAM.
    function automatic logic is_write_state(capture_state_t s);
        return s inside {PRE, ARM, WAIT, POST};
    endfunction

    // States reported as an acquisition in progress.
    function automatic logic is_busy_state(capture_state_t s);
        return s inside {LOAD, PRE, ARM, WAIT, POST};
    endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// Signal bundle between the host/trigger/RAM side (master) and the capture
// sequencer (slave).
interface capture_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  start;
    logic                  abort;
    logic                  valid;
    logic                  trig_run;
    logic [ADDR_WIDTH-1:0] pre_samples;
    logic [ADDR_WIDTH-1:0] post_samples;

    logic                  load_trigs;
    logic                  arm;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] trig_addr;
    logic                  busy;
    logic                  done;

    modport master (
        output start, abort, valid, trig_run, pre_samples, post_samples,
        input  load_trigs, arm, wr_en, wr_addr, trig_addr, busy, done
    );

    modport slave (
        input  start, abort, valid, trig_run, pre_samples, post_samples,
        output load_trigs, arm, wr_en, wr_addr, trig_addr, busy, done
    );
endinterface

// File: rtl/capture_sequencer_sample_counter.sv
// Loadable count-up sample counter. hit flags the increment that brings the
// count up to target, so the caller can leave its phase in that same cycle.
module sample_counter #(
    parameter int WIDTH = 12
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] target,
    output logic             hit
);
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_inc;

    assign count_inc = count + WIDTH'(1);
    assign hit       = inc && (count_inc == target);

    // Restart from zero at each new capture, otherwise advance once per counted sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count_inc;
        end
    end
endmodule

// File: rtl/capture_sequencer.sv
// Capture sequencer: drives the trigger unit's load/arm strobes, generates
// circular sample-RAM write addresses, counts pre/post-trigger samples and
// records the address of the trigger sample.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no capture; waiting for start
//   LOAD  | one cycle, load_trigs pulse to the trigger unit
//   PRE   | writing pre-trigger samples until the latched pre count is met
//   ARM   | one cycle, arm pulse; sample still written
//   WAIT  | circular writes until trig_run; trigger address captured
//   POST  | writing post-trigger samples until the latched post count is met
//   DONE  | capture complete, done held until the next accepted start
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic     clock,
    input  logic     reset_n,
    capture_if.slave bus
);
    capture_state_t        state;
    capture_state_t        state_nxt;
    logic [ADDR_WIDTH-1:0] pre_q;
    logic [ADDR_WIDTH-1:0] post_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [ADDR_WIDTH-1:0] trig_addr_q;
    logic                  load_trigs_q;
    logic                  arm_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  start_ok;
    logic                  wr_en;
    logic                  trig_hit;
    logic                  pre_hit;
    logic                  post_hit;

    // Abort outranks start, and start is only honoured between captures.
    assign start_ok = bus.start && !bus.abort && (state == IDLE || state == DONE);
    assign wr_en    = bus.valid && !bus.abort && is_write_state(state);
    assign trig_hit = (state == WAIT) && bus.trig_run && !bus.abort;

    sample_counter #(.WIDTH(ADDR_WIDTH)) u_pre_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (start_ok),
        .inc     (wr_en && (state == PRE)),
        .target  (pre_q),
        .hit     (pre_hit)
    );

    sample_counter #(.WIDTH(ADDR_WIDTH)) u_post_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (start_ok),
        .inc     (wr_en && (state == POST)),
        .target  (post_q),
        .hit     (post_hit)
    );

    // Next-state decode; the registered strobes below are derived from it.
    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: if (bus.start) state_nxt = LOAD;
                LOAD:       state_nxt = (pre_q == '0) ? ARM : PRE;
                PRE:        if (pre_hit) state_nxt = ARM;
                ARM:        state_nxt = WAIT;
                WAIT:       if (bus.trig_run) state_nxt = (post_q == '0) ? DONE : POST;
                POST:       if (post_hit) state_nxt = DONE;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    // State, registered strobes/status, latched counts and the address registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            load_trigs_q <= 1'b0;
            arm_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pre_q        <= '0;
            post_q       <= '0;
            wr_addr_q    <= '0;
            trig_addr_q  <= '0;
        end else begin
            state        <= state_nxt;
            load_trigs_q <= (state_nxt == LOAD);
            arm_q        <= (state_nxt == ARM);
            busy_q       <= is_busy_state(state_nxt);
            done_q       <= (state_nxt == DONE);

            if (start_ok) begin
                pre_q     <= bus.pre_samples;
                post_q    <= bus.post_samples;
                wr_addr_q <= '0;
            end else if (wr_en) begin
                wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
            end

            // The trigger sample is the one written this cycle, or the last
            // one already written if no write accompanies trig_run.
            if (trig_hit) begin
                trig_addr_q <= wr_en ? wr_addr_q : (wr_addr_q - ADDR_WIDTH'(1));
            end
        end
    end

    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.trig_addr  = trig_addr_q;
    assign bus.load_trigs = load_trigs_q;
    assign bus.arm        = arm_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_capture_sequencer.sv
// Bench for capture_sequencer: a constant-vector table for the nominal run,
// hand-written corner sequences, and randomized traffic against a behavioural
// model that tracks remaining samples and addresses with plain integers.
module tb_capture_sequencer;
    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;
    localparam int NVEC  = 19;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_PRE  = 2;
    localparam int P_ARM  = 3;
    localparam int P_WAIT = 4;
    localparam int P_POST = 5;
    localparam int P_DONE = 6;

    typedef struct {
        logic start, abort, valid, trig;
        logic exp_load, exp_arm, exp_we, exp_busy, exp_done;
        int   exp_addr, exp_trig;
    } vec_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    capture_if #(.ADDR_WIDTH(AW)) bus ();

    capture_sequencer #(.ADDR_WIDTH(AW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   checks = 0;
    int   errors = 0;
    vec_t tbl [NVEC];

    int m_phase, m_pre_lat, m_post_lat, m_left, m_addr, m_trig;
    int n_wr, wr_no_valid;
    logic last_we;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t row(logic s, logic a, logic v, logic t, logic l, logic ar,
                                 logic we, logic b, logic d, int addr, int trg);
        vec_t r;
        r.start = s; r.abort = a; r.valid = v; r.trig = t;
        r.exp_load = l; r.exp_arm = ar; r.exp_we = we; r.exp_busy = b; r.exp_done = d;
        r.exp_addr = addr; r.exp_trig = trg;
        return r;
    endfunction

    function automatic void model_reset();
        m_phase = P_IDLE; m_pre_lat = 0; m_post_lat = 0; m_left = 0; m_addr = 0; m_trig = 0;
    endfunction

    function automatic logic model_we(logic v, logic a);
        return v && !a && (m_phase == P_PRE || m_phase == P_ARM ||
                           m_phase == P_WAIT || m_phase == P_POST);
    endfunction

    function automatic void model_update(logic s, logic a, logic v, logic t);
        logic we;
        we = model_we(v, a);
        if (a) begin
            m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE, P_DONE: if (s) begin
                    m_pre_lat  = int'(bus.pre_samples);
                    m_post_lat = int'(bus.post_samples);
                    m_addr     = 0;
                    m_phase    = P_LOAD;
                end
                P_LOAD: begin
                    m_left  = m_pre_lat;
                    m_phase = (m_pre_lat == 0) ? P_ARM : P_PRE;
                end
                P_PRE: if (we) begin
                    m_left--;
                    if (m_left == 0) m_phase = P_ARM;
                end
                P_ARM: m_phase = P_WAIT;
                P_WAIT: if (t) begin
                    m_trig  = we ? m_addr : (m_addr + DEPTH - 1) % DEPTH;
                    m_left  = m_post_lat;
                    m_phase = (m_post_lat == 0) ? P_DONE : P_POST;
                end
                P_POST: if (we) begin
                    m_left--;
                    if (m_left == 0) m_phase = P_DONE;
                end
                default: ;
            endcase
            if (we) m_addr = (m_addr + 1) % DEPTH;
        end
    endfunction

    task automatic set_counts(input int p, input int q);
        bus.pre_samples  = AW'(p);
        bus.post_samples = AW'(q);
    endtask

    // One clock: drive at posedge+1, compare at negedge, advance model at posedge.
    task automatic step(input logic s, input logic a, input logic v, input logic t,
                        input int r);
        bus.start = s; bus.abort = a; bus.valid = v; bus.trig_run = t;
        @(negedge clock);
        check("wr_en",      bus.wr_en,      model_we(v, a));
        check("wr_addr",    bus.wr_addr,    m_addr);
        check("trig_addr",  bus.trig_addr,  m_trig);
        check("load_trigs", bus.load_trigs, m_phase == P_LOAD);
        check("arm",        bus.arm,        m_phase == P_ARM);
        check("busy",       bus.busy,       m_phase >= P_LOAD && m_phase <= P_POST);
        check("done",       bus.done,       m_phase == P_DONE);
        if (r >= 0) begin
            check($sformatf("vec%0d_load", r),  bus.load_trigs, tbl[r].exp_load);
            check($sformatf("vec%0d_arm", r),   bus.arm,        tbl[r].exp_arm);
            check($sformatf("vec%0d_wr_en", r), bus.wr_en,      tbl[r].exp_we);
            check($sformatf("vec%0d_busy", r),  bus.busy,       tbl[r].exp_busy);
            check($sformatf("vec%0d_done", r),  bus.done,       tbl[r].exp_done);
            check($sformatf("vec%0d_addr", r),  bus.wr_addr,    tbl[r].exp_addr);
            check($sformatf("vec%0d_trig", r),  bus.trig_addr,  tbl[r].exp_trig);
        end
        last_we = (bus.wr_en === 1'b1);
        if (last_we) n_wr++;
        if (last_we && !v) wr_no_valid++;
        @(posedge clock);
        model_update(s, a, v, t);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int   ph, pre_w, wait_w, post_w, prev_addr;
    logic seen_wrap, fin, gv, gt, r_s, r_a, r_v, r_t;

    initial begin
        //            s a v t   ld ar we bs dn  addr trig
        tbl[0]  = row(1,0,1,0,  0, 0, 0, 0, 0,   0,  0);
        tbl[1]  = row(0,0,1,0,  1, 0, 0, 1, 0,   0,  0);
        tbl[2]  = row(0,0,1,0,  0, 0, 1, 1, 0,   0,  0);
        tbl[3]  = row(0,0,1,0,  0, 0, 1, 1, 0,   1,  0);
        tbl[4]  = row(0,0,1,1,  0, 0, 1, 1, 0,   2,  0);
        tbl[5]  = row(0,0,1,0,  0, 0, 1, 1, 0,   3,  0);
        tbl[6]  = row(0,0,1,1,  0, 1, 1, 1, 0,   4,  0);
        tbl[7]  = row(0,0,1,0,  0, 0, 1, 1, 0,   5,  0);
        tbl[8]  = row(1,0,1,0,  0, 0, 1, 1, 0,   6,  0);
        tbl[9]  = row(0,0,1,1,  0, 0, 1, 1, 0,   7,  0);
        tbl[10] = row(0,0,1,0,  0, 0, 1, 1, 0,   8,  7);
        tbl[11] = row(0,0,1,0,  0, 0, 1, 1, 0,   9,  7);
        tbl[12] = row(0,0,1,0,  0, 0, 1, 1, 0,  10,  7);
        tbl[13] = row(0,0,1,0,  0, 0, 0, 0, 1,  11,  7);
        tbl[14] = row(0,0,0,0,  0, 0, 0, 0, 1,  11,  7);
        tbl[15] = row(1,0,1,0,  0, 0, 0, 0, 1,  11,  7);
        tbl[16] = row(0,0,0,0,  1, 0, 0, 1, 0,   0,  7);
        tbl[17] = row(0,1,1,0,  0, 0, 0, 1, 0,   0,  7);
        tbl[18] = row(0,0,1,0,  0, 0, 0, 0, 0,   0,  7);

        bus.start = 0; bus.abort = 0; bus.valid = 0; bus.trig_run = 0;
        set_counts(0, 0);
        model_reset();
        n_wr = 0; wr_no_valid = 0; last_we = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Nominal run pre=4 post=3, then start-in-DONE and abort in PRE.
        set_counts(4, 3);
        for (int i = 0; i < NVEC; i++) begin
            step(tbl[i].start, tbl[i].abort, tbl[i].valid, tbl[i].trig, i);
        end

        // pre=0, post=0: LOAD straight to ARM, DONE right after the trigger cycle.
        set_counts(0, 0);
        step(1, 0, 1, 0, -1);
        step(0, 0, 1, 0, -1);
        check("zero_direct_arm", bus.arm, 1'b1);
        step(0, 0, 1, 0, -1);
        step(0, 0, 1, 0, -1);
        step(0, 0, 1, 1, -1);
        check("zero_done", bus.done, 1'b1);
        check("zero_trig_addr", bus.trig_addr, 2);
        step(0, 0, 1, 0, -1);
        check("zero_no_post_writes", bus.wr_addr, 3);

        // Wrap: pre=2, post=2, WAIT runs past the end of the buffer.
        set_counts(2, 2);
        seen_wrap = 1'b0;
        for (int i = 0; i < 5; i++) step(i == 0, 0, 1, 0, -1);
        for (int k = 0; k < 4110; k++) begin
            prev_addr = int'(bus.wr_addr);
            step(0, 0, 1, 0, -1);
            if (prev_addr == DEPTH - 1 && bus.wr_addr == '0) seen_wrap = 1'b1;
        end
        step(0, 0, 1, 1, -1);
        check("wrap_seen", seen_wrap, 1'b1);
        check("wrap_trig_addr", bus.trig_addr, 17);
        step(0, 0, 1, 0, -1);
        step(0, 0, 1, 0, -1);
        check("wrap_done", bus.done, 1'b1);
        check("wrap_final_addr", bus.wr_addr, (17 + 3) % DEPTH);

        // Gapped valid, 1 in 3 cycles, pre=3 post=2.
        set_counts(3, 2);
        n_wr = 0; wr_no_valid = 0; pre_w = 0; wait_w = 0; post_w = 0; fin = 1'b0;
        for (int c = 0; c < 300 && !fin; c++) begin
            gv = (c % 3 == 0);
            ph = m_phase;
            gt = (ph == P_WAIT) && (wait_w >= 2) && gv;
            step(c == 0, 0, gv, gt, -1);
            if (last_we) begin
                case (ph)
                    P_PRE:          pre_w++;
                    P_ARM, P_WAIT:  wait_w++;
                    P_POST:         post_w++;
                    default: ;
                endcase
            end
            if (bus.done === 1'b1) fin = 1'b1;
        end
        check("gap_finished", fin, 1'b1);
        check("gap_pre_writes", pre_w, 3);
        check("gap_post_writes", post_w, 2);
        check("gap_total_writes", n_wr, 5 + wait_w);
        check("gap_final_addr", bus.wr_addr, n_wr % DEPTH);
        check("gap_wr_without_valid", wr_no_valid, 0);

        // Abort in WAIT together with start, then a clean capture.
        set_counts(1, 1);
        for (int i = 0; i < 5; i++) step(i == 0, 0, 1, 0, -1);
        step(1, 1, 1, 0, -1);
        check("abort_wr_en", bus.wr_en, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_done", bus.done, 1'b0);
        step(1, 0, 1, 0, -1);
        step(0, 0, 1, 0, -1);
        step(0, 0, 1, 0, -1);
        step(0, 0, 1, 0, -1);
        step(0, 0, 1, 1, -1);
        step(0, 0, 1, 0, -1);
        check("clean_done", bus.done, 1'b1);
        check("clean_trig_addr", bus.trig_addr, 2);
        check("clean_final_addr", bus.wr_addr, 4);

        // Reset asserted mid-POST.
        set_counts(2, 6);
        for (int i = 0; i < 8; i++) step(i == 0, 0, 1, i == 5, -1);
        check("pre_reset_in_post", bus.busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_trig_addr", bus.trig_addr, 0);
        check("rst_load", bus.load_trigs, 1'b0);
        check("rst_arm", bus.arm, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_wr_en", bus.wr_en, 1'b0);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 1, -1);
            check("post_rst_no_load", bus.load_trigs, 1'b0);
            check("post_rst_no_arm", bus.arm, 1'b0);
        end
        set_counts(0, 1);
        step(1, 0, 1, 0, -1);
        step(0, 0, 1, 0, -1);
        step(0, 0, 1, 0, -1);
        step(0, 0, 1, 1, -1);
        step(0, 0, 1, 0, -1);
        check("post_rst_done", bus.done, 1'b1);
        check("post_rst_final_addr", bus.wr_addr, 3);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            set_counts($urandom_range(0, 6), $urandom_range(0, 6));
            r_s = ($urandom_range(0, 15) == 0);
            r_a = ($urandom_range(0, 49) == 0);
            r_v = ($urandom_range(0, 2) != 0);
            r_t = ($urandom_range(0, 7) == 0);
            step(r_s, r_a, r_v, r_t, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Sequences one logic-analyzer acquisition around the basic trigger unit.
- Drives the trigger unit's load_trigs and arm strobes, and generates circular sample-memory write addresses.
- Counts pre-trigger and post-trigger samples, and records the memory address of the trigger sample.
- Sits between the host command/register block and the trigger unit plus sample RAM.

Parameters:
- ADDR_WIDTH, 12: sample-memory address width. Depth is 2^ADDR_WIDTH. Also the width of the pre/post counts.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle capture request
- abort  in  1  cancel the capture in progress
- valid  in  1  sample strobe; the same signal feeds the trigger unit
- trig_run  in  1  one-cycle trigger pulse from the trigger unit
- pre_samples  in  ADDR_WIDTH  pre-trigger sample count, latched on an accepted start
- post_samples  in  ADDR_WIDTH  post-trigger sample count, latched on an accepted start
- load_trigs  out  1  one-cycle pulse to the trigger unit
- arm  out  1  one-cycle pulse to the trigger unit
- wr_en  out  1  sample-RAM write enable
- wr_addr  out  ADDR_WIDTH  sample-RAM write address
- trig_addr  out  ADDR_WIDTH  address of the last sample written before trig_run was seen
- busy  out  1  capture in progress
- done  out  1  capture complete, level

Behaviour:
- Clock and reset: a single clock. reset_n is asynchronous and active-low.
- Reset values: state IDLE; load_trigs, arm, busy, done = 0; wr_addr, trig_addr = 0; latched counts = 0.
- States: IDLE, LOAD, PRE, ARM, WAIT, POST, DONE.
- IDLE/DONE:
  - start latches pre/post counts, clears wr_addr, clears done, and moves to LOAD.
  - In DONE, done stays 1 until the next accepted start.
- LOAD: load_trigs=1 for exactly this one cycle. Next state is PRE, or ARM if the latched pre count is 0.
- PRE: count valid writes. Move to ARM in the cycle the count reaches the latched pre value.
- ARM: arm=1 for exactly this one cycle, then go to WAIT. trig_run is ignored in PRE and ARM.
- WAIT: on trig_run:
  - trig_addr <= wr_addr-1 (mod 2^ADDR_WIDTH), or wr_addr-1 counted after this cycle's write if wr_en is also asserted, i.e. the current write address.
  - Go to POST, or DONE if the latched post count is 0.
- POST: count valid writes. Go to DONE in the cycle the count reaches the latched post value.
- Write path:
  - wr_en = valid AND state in {PRE, ARM, WAIT, POST} AND NOT abort. This is combinational, with zero latency from valid.
  - wr_addr increments by 1 after each wr_en and wraps from 2^ADDR_WIDTH-1 to 0.
  - WAIT overwrites the buffer circularly with no limit.
- busy = 1 in LOAD through POST.
- load_trigs and arm are registered outputs, decoded from the next state.
- Counting: only cycles with valid=1 count; gaps in valid stall the counters. The max pre/post count is 2^ADDR_WIDTH-1.
- Abort: in any non-IDLE state, go to IDLE next cycle with no further writes and done=0. Abort wins over a simultaneous start.
- start while busy is ignored.
- start coincident with DONE begins a new capture; done falls the next cycle.
- reset_n asserted mid-capture returns immediately to reset values. No pending pulse is emitted after release.

Decomposition:
- Shared package capture_pkg: the state enum type capture_state_t.
- One sub-module, sample_counter: a loadable count-up counter with a terminal-match flag. It is instanced twice (pre, post), or once and reloaded between phases.

Test Plan:
- Nominal run, ADDR_WIDTH=12, pre=4, post=3, valid continuous, trig_run on the 3rd WAIT cycle:
  - load_trigs 1 cycle after start.
  - Writes 0..3 in PRE, then arm pulse.
  - trig_addr equals the address of the sample written when trig_run arrives.
  - 3 POST writes, then done=1 and busy=0.
- pre=0, post=0, trig_run 2 cycles after arm:
  - LOAD goes directly to ARM.
  - DONE follows the trig_run cycle with no POST writes.
- Wrap, ADDR_WIDTH=4, pre=2, post=2, trig_run after 20 WAIT writes:
  - wr_addr sequence passes 15 -> 0.
  - trig_addr equals the wrapped address.
  - Final wr_addr equals (trig_addr+3) mod 16.
- Gapped valid (1 of every 3 cycles), pre=3, post=2:
  - Counts advance only on valid.
  - wr_en never asserts without valid.
  - Total writes equal pre + WAIT writes + post.
- Abort in WAIT, with start asserted simultaneously:
  - IDLE next cycle, wr_en=0, done=0, busy=0.
  - A subsequent start performs a full clean capture.
- reset_n low mid-POST:
  - All outputs return to reset values asynchronously.
  - No load_trigs/arm pulse after release.
  - start then works normally.
